// File: rtl/reg_operand_fetch_if.sv
// ---------------------------------------------------------------------------
// reg_operand_fetch_if
//   Bundles every non-clock/reset signal of the operand-fetch stage: the issue
//   handshake, register-file read and write ports, the writeback bus, the
//   registered operand bundle towards execute and the scoreboard view.
//   Modports:
//     slave  - the operand-fetch stage itself
//     master - the environment (issue logic, register file, execute, writeback)
// ---------------------------------------------------------------------------
interface reg_operand_fetch_if #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 4
);
   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   // issue side
   logic                  i_issue_valid;
   logic                  o_issue_ready;
   logic [ADDR_WIDTH-1:0] i_src_a_addr;
   logic [ADDR_WIDTH-1:0] i_src_b_addr;
   logic [ADDR_WIDTH-1:0] i_dst_addr;
   logic                  i_dst_en;
   // register file read ports
   logic [ADDR_WIDTH-1:0] o_reg_a_addr_r;
   logic [ADDR_WIDTH-1:0] o_reg_b_addr_r;
   logic [REG_WIDTH-1:0]  i_reg_a_val_r;
   logic [REG_WIDTH-1:0]  i_reg_b_val_r;
   // writeback and register file write port
   logic                  i_wb_valid;
   logic [ADDR_WIDTH-1:0] i_wb_addr;
   logic [REG_WIDTH-1:0]  i_wb_val;
   logic [ADDR_WIDTH-1:0] o_reg_addr_w;
   logic [REG_WIDTH-1:0]  o_reg_val_w;
   logic                  o_write_en;
   // operand bundle towards execute
   logic                  o_op_valid;
   logic                  i_op_ready;
   logic [REG_WIDTH-1:0]  o_op_a;
   logic [REG_WIDTH-1:0]  o_op_b;
   logic [ADDR_WIDTH-1:0] o_op_dst_addr;
   logic                  o_op_dst_en;
   // scoreboard
   logic [NUM_REGS-1:0]   o_busy_mask;

   modport slave (
      input  i_issue_valid, i_src_a_addr, i_src_b_addr, i_dst_addr, i_dst_en,
      input  i_reg_a_val_r, i_reg_b_val_r,
      input  i_wb_valid, i_wb_addr, i_wb_val,
      input  i_op_ready,
      output o_issue_ready, o_reg_a_addr_r, o_reg_b_addr_r,
      output o_reg_addr_w, o_reg_val_w, o_write_en,
      output o_op_valid, o_op_a, o_op_b, o_op_dst_addr, o_op_dst_en,
      output o_busy_mask
   );

   modport master (
      output i_issue_valid, i_src_a_addr, i_src_b_addr, i_dst_addr, i_dst_en,
      output i_reg_a_val_r, i_reg_b_val_r,
      output i_wb_valid, i_wb_addr, i_wb_val,
      output i_op_ready,
      input  o_issue_ready, o_reg_a_addr_r, o_reg_b_addr_r,
      input  o_reg_addr_w, o_reg_val_w, o_write_en,
      input  o_op_valid, o_op_a, o_op_b, o_op_dst_addr, o_op_dst_en,
      input  o_busy_mask
   );
endinterface

// File: rtl/reg_operand_fetch.sv
// ---------------------------------------------------------------------------
// reg_operand_fetch
//   Operand-fetch stage sitting directly upstream of the register file.
//   Accepts issued ops, reads both sources from the register file, forwards
//   same-cycle writeback data, tracks pending destination writes in a busy-bit
//   scoreboard, stalls on RAW/WAW hazards and registers the operand bundle for
//   execute (one cycle latency, full throughput).
//   Ports:
//     i_clk  - clock, all state changes on the rising edge
//     i_rst  - synchronous active-high reset
//     bus    - reg_operand_fetch_if.slave: issue handshake, regfile read/write
//              ports, writeback bus, operand bundle and busy mask
// ---------------------------------------------------------------------------
module reg_operand_fetch #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   reg_operand_fetch_if.slave     bus
);
   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [NUM_REGS-1:0]   busy_q,        busy_d;
   logic                  op_valid_q,    op_valid_d;
   logic [REG_WIDTH-1:0]  op_a_q,        op_a_d;
   logic [REG_WIDTH-1:0]  op_b_q,        op_b_d;
   logic [ADDR_WIDTH-1:0] op_dst_addr_q, op_dst_addr_d;
   logic                  op_dst_en_q,   op_dst_en_d;

   logic clr_a, clr_b, clr_dst;
   logic eff_busy_a, eff_busy_b, eff_busy_dst;
   logic hazard;
   logic issue_ready;
   logic accept;
   logic [REG_WIDTH-1:0] src_a_val, src_b_val;

   // A writeback landing this cycle releases its register, so an op waiting on
   // it may issue in the same cycle and take the value from the bypass.
   assign clr_a        = bus.i_wb_valid && (bus.i_wb_addr == bus.i_src_a_addr);
   assign clr_b        = bus.i_wb_valid && (bus.i_wb_addr == bus.i_src_b_addr);
   assign clr_dst      = bus.i_wb_valid && (bus.i_wb_addr == bus.i_dst_addr);
   assign eff_busy_a   = busy_q[bus.i_src_a_addr] && !clr_a;
   assign eff_busy_b   = busy_q[bus.i_src_b_addr] && !clr_b;
   assign eff_busy_dst = busy_q[bus.i_dst_addr]   && !clr_dst;
   assign hazard       = eff_busy_a || eff_busy_b || (bus.i_dst_en && eff_busy_dst);

   // Ready looks only at the payload, never at i_issue_valid, so upstream may
   // wait for ready without creating a combinational loop.
   assign issue_ready = !i_rst && (!op_valid_q || bus.i_op_ready) && !hazard;
   assign accept      = bus.i_issue_valid && issue_ready;

   // The regfile only commits writeback data on the next edge; forward it now.
   assign src_a_val = clr_a ? bus.i_wb_val : bus.i_reg_a_val_r;
   assign src_b_val = clr_b ? bus.i_wb_val : bus.i_reg_b_val_r;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      busy_d        = busy_q;
      op_valid_d    = op_valid_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      op_dst_addr_d = op_dst_addr_q;
      op_dst_en_d   = op_dst_en_q;

      // Clear before set: an op issued against the register being written back
      // re-marks it busy, so the set must win.
      if (bus.i_wb_valid) begin
         busy_d[bus.i_wb_addr] = 1'b0;
      end
      if (accept && bus.i_dst_en) begin
         busy_d[bus.i_dst_addr] = 1'b1;
      end

      if (accept) begin
         op_valid_d    = 1'b1;
         op_a_d        = src_a_val;
         op_b_d        = src_b_val;
         op_dst_addr_d = bus.i_dst_addr;
         op_dst_en_d   = bus.i_dst_en;
      end else if (op_valid_q && bus.i_op_ready) begin
         op_valid_d    = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy_q        <= '0;
         op_valid_q    <= 1'b0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         op_dst_addr_q <= '0;
         op_dst_en_q   <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         op_valid_q    <= op_valid_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         op_dst_addr_q <= op_dst_addr_d;
         op_dst_en_q   <= op_dst_en_d;
      end
   end

   assign bus.o_issue_ready  = issue_ready;
   assign bus.o_reg_a_addr_r = bus.i_src_a_addr;
   assign bus.o_reg_b_addr_r = bus.i_src_b_addr;
   assign bus.o_reg_addr_w   = bus.i_wb_addr;
   assign bus.o_reg_val_w    = bus.i_wb_val;
   assign bus.o_write_en     = bus.i_wb_valid && !i_rst;
   assign bus.o_op_valid     = op_valid_q;
   assign bus.o_op_a         = op_a_q;
   assign bus.o_op_b         = op_b_q;
   assign bus.o_op_dst_addr  = op_dst_addr_q;
   assign bus.o_op_dst_en    = op_dst_en_q;
   assign bus.o_busy_mask    = busy_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_reg_operand_fetch
//   Directed bench for reg_operand_fetch. A behavioural register file sits on
//   the read/write ports; expected operand bundles are queued when an op is
//   issued and a monitor pops and compares them on each execute handshake.
//   Ready, busy mask and write-port values are checked directly by stimulus.
// ---------------------------------------------------------------------------
module tb_reg_operand_fetch;
   localparam int RW = 32;
   localparam int AW = 4;

   typedef struct packed {
      logic [RW-1:0] a;
      logic [RW-1:0] b;
      logic [AW-1:0] dst;
      logic          en;
   } bundle_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   int      n_cmp = 0;
   int      n_bad = 0;
   bundle_t exp_q[$];
   logic [RW-1:0] regs [16];

   reg_operand_fetch_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

   reg_operand_fetch #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // behavioural register file: combinational read, write on rising edge
   always_comb begin
      bus.i_reg_a_val_r = regs[bus.o_reg_a_addr_r];
      bus.i_reg_b_val_r = regs[bus.o_reg_b_addr_r];
   end
   always @(posedge clk) begin
      if (bus.o_write_en) regs[bus.o_reg_addr_w] <= bus.o_reg_val_w;
   end

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // monitor: compare each bundle that execute accepts
   always @(negedge clk) begin
      if (!rst && bus.o_op_valid && bus.i_op_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_bundle", 1, 0);
         end else begin
            bundle_t e;
            e = exp_q.pop_front();
            check("bundle_a",   bus.o_op_a, e.a);
            check("bundle_b",   bus.o_op_b, e.b);
            check("bundle_dst", {28'd0, bus.o_op_dst_addr}, {28'd0, e.dst});
            check("bundle_en",  {31'd0, bus.o_op_dst_en}, {31'd0, e.en});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                        input logic [AW-1:0] d, input logic en);
      bus.i_issue_valid = 1'b1;
      bus.i_src_a_addr  = sa;
      bus.i_src_b_addr  = sb;
      bus.i_dst_addr    = d;
      bus.i_dst_en      = en;
      #1;
   endtask

   task automatic idle();
      bus.i_issue_valid = 1'b0;
      #1;
   endtask

   task automatic wb(input logic v, input logic [AW-1:0] a, input logic [RW-1:0] val);
      bus.i_wb_valid = v;
      bus.i_wb_addr  = a;
      bus.i_wb_val   = val;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h100 + i;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      bus.i_issue_valid = 1'b0;
      bus.i_src_a_addr  = '0;
      bus.i_src_b_addr  = '0;
      bus.i_dst_addr    = '0;
      bus.i_dst_en      = 1'b0;
      bus.i_wb_valid    = 1'b0;
      bus.i_wb_addr     = '0;
      bus.i_wb_val      = '0;
      bus.i_op_ready    = 1'b1;

      // ---- reset state ----
      step();
      step();
      check("rst_issue_ready", {31'd0, bus.o_issue_ready}, 0);
      rst = 1'b0;
      #1;
      check("rst_busy",     {16'd0, bus.o_busy_mask}, 0);
      check("rst_op_valid", {31'd0, bus.o_op_valid}, 0);
      check("rst_op_a",     bus.o_op_a, 0);
      check("rst_op_dst",   {27'd0, bus.o_op_dst_en, bus.o_op_dst_addr}, 0);

      // ---- 1: basic issue r1=5, r2=7 -> dst 3 ----
      issue(4'd1, 4'd2, 4'd3, 1'b1);
      check("t1_ready", {31'd0, bus.o_issue_ready}, 1);
      exp_q.push_back('{a: 32'd5, b: 32'd7, dst: 4'd3, en: 1'b1});
      step();
      idle();
      check("t1_op_valid", {31'd0, bus.o_op_valid}, 1);
      check("t1_busy", {16'd0, bus.o_busy_mask}, 32'h0008);

      // ---- 2: RAW on r3, resolved by same-cycle writeback with bypass ----
      issue(4'd3, 4'd1, 4'd5, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("t2_stall", {31'd0, bus.o_issue_ready}, 0);
         step();
      end
      wb(1'b1, 4'd3, 32'h99);
      check("t2_ready_bypass", {31'd0, bus.o_issue_ready}, 1);
      exp_q.push_back('{a: 32'h99, b: 32'd5, dst: 4'd5, en: 1'b1});
      step();
      idle();
      wb(1'b0, 4'd0, 32'h0);
      check("t2_busy", {16'd0, bus.o_busy_mask}, 32'h0020);

      // ---- 3: dst_en=0 skips WAW; WAW on r5 resolved by wb, set wins ----
      issue(4'd1, 4'd2, 4'd5, 1'b0);
      check("t3_no_waw", {31'd0, bus.o_issue_ready}, 1);
      exp_q.push_back('{a: 32'd5, b: 32'd7, dst: 4'd5, en: 1'b0});
      step();
      check("t3_busy_en0", {16'd0, bus.o_busy_mask}, 32'h0020);
      issue(4'd1, 4'd2, 4'd5, 1'b1);
      check("t3_waw_stall", {31'd0, bus.o_issue_ready}, 0);
      step();
      wb(1'b1, 4'd5, 32'h55);
      check("t3_waw_release", {31'd0, bus.o_issue_ready}, 1);
      exp_q.push_back('{a: 32'd5, b: 32'd7, dst: 4'd5, en: 1'b1});
      step();
      idle();
      wb(1'b0, 4'd0, 32'h0);
      check("t3_busy_set_wins", {16'd0, bus.o_busy_mask}, 32'h0020);

      // ---- 6: writeback to non-busy reg 9 ----
      wb(1'b1, 4'd9, 32'h1234);
      check("t6_we",    {31'd0, bus.o_write_en}, 1);
      check("t6_waddr", {28'd0, bus.o_reg_addr_w}, 9);
      check("t6_wval",  bus.o_reg_val_w, 32'h1234);
      step();
      wb(1'b0, 4'd0, 32'h0);
      check("t6_busy", {16'd0, bus.o_busy_mask}, 32'h0020);

      // ---- 4: output hold under backpressure, then no-bubble handoff ----
      bus.i_op_ready = 1'b0;
      issue(4'd1, 4'd2, 4'd6, 1'b1);
      check("t4_first_ready", {31'd0, bus.o_issue_ready}, 1);
      exp_q.push_back('{a: 32'd5, b: 32'd7, dst: 4'd6, en: 1'b1});
      step();
      issue(4'd9, 4'd3, 4'd7, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("t4_bp_ready", {31'd0, bus.o_issue_ready}, 0);
         check("t4_hold_a",   bus.o_op_a, 32'd5);
         check("t4_hold_b",   bus.o_op_b, 32'd7);
         check("t4_hold_dst", {28'd0, bus.o_op_dst_addr}, 6);
         step();
      end
      bus.i_op_ready = 1'b1;
      #1;
      check("t4_ready_release", {31'd0, bus.o_issue_ready}, 1);
      exp_q.push_back('{a: 32'h1234, b: 32'h99, dst: 4'd7, en: 1'b1});
      step();
      idle();
      check("t4_no_bubble", {31'd0, bus.o_op_valid}, 1);
      check("t4_busy", {16'd0, bus.o_busy_mask}, 32'h00E0);
      step();

      // ---- 5: reset with a pending bundle and busy = 0xF0 ----
      issue(4'd0, 4'd0, 4'd4, 1'b1);
      exp_q.push_back('{a: 32'h100, b: 32'h100, dst: 4'd4, en: 1'b1});
      step();
      idle();
      bus.i_op_ready = 1'b0;
      #1;
      check("t5_busy_pre", {16'd0, bus.o_busy_mask}, 32'h00F0);
      check("t5_valid_pre", {31'd0, bus.o_op_valid}, 1);
      rst = 1'b1;
      wb(1'b1, 4'd10, 32'hDEAD);
      check("t5_we_in_rst", {31'd0, bus.o_write_en}, 0);
      check("t5_ready_in_rst", {31'd0, bus.o_issue_ready}, 0);
      step();
      check("t5_busy_post", {16'd0, bus.o_busy_mask}, 0);
      check("t5_valid_post", {31'd0, bus.o_op_valid}, 0);
      exp_q.delete();
      rst = 1'b0;
      wb(1'b0, 4'd0, 32'h0);
      bus.i_op_ready = 1'b1;
      step();
      check("t5_reg10_unwritten", regs[10], 32'h10A);

      // ---- drain ----
      for (int i = 0; i < 4; i++) step();
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
